// File: rtl/sumsq_accum.sv
// Sum-of-squares accumulator feeding the normalization sqrt stage.
// Define SUMSQ_PIPE_EN to register the square ahead of the adder; this adds a DRAIN cycle.
module sumsq_accum #(
  parameter int DATA_W = 8,
  parameter int N_ELEM = 4,
  parameter int ACC_W  = 2*DATA_W + $clog2(N_ELEM)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              sqrt_done,
  output logic              go,
  output logic [ACC_W-1:0]  sum_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_ELEM);
  localparam int SQ_W  = 2*DATA_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    DRAIN = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_add, acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, last;

  logic signed [DATA_W-1:0] d_s;
  logic signed [SQ_W-1:0]   sq_s;
  logic [SQ_W-1:0]          sq;

  // A square is never negative, so the signed product reads back as unsigned.
  assign d_s    = $signed(in_data);
  assign sq_s   = d_s * d_s;
  assign sq     = $unsigned(sq_s);
  assign accept = (state == ACC) && in_valid;
  assign last   = accept && (cnt == CNT_W'(N_ELEM - 1));

`ifdef SUMSQ_PIPE_EN
  logic [SQ_W-1:0] sq_r;
  logic            sq_vld;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sq_r   <= '0;
      sq_vld <= 1'b0;
    end else begin
      if (accept) sq_r <= sq;
      sq_vld <= accept;
    end
  end

  always_comb begin
    acc_add = '0;
    if (sq_vld && (state == ACC || state == DRAIN)) acc_add = ACC_W'(sq_r);
  end
`else
  always_comb begin
    acc_add = '0;
    if (accept) acc_add = ACC_W'(sq);
  end
`endif

  assign acc_nxt = acc + acc_add;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    go        = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
`ifdef SUMSQ_PIPE_EN
        if (last) state_nxt = DRAIN;
`else
        if (last) state_nxt = ISSUE;
`endif
      end
      DRAIN: state_nxt = ISSUE;
      ISSUE: begin
        go        = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (sqrt_done) state_nxt = IDLE;
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        acc <= '0;
        cnt <= '0;
      end
    end else if (state == ACC || state == DRAIN) begin
      acc <= acc_nxt;
      if (accept) cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

  // sum_out is loaded only on the edge that enters ISSUE, so it is valid while go is high.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) sum_out <= '0;
    else if (state_nxt == ISSUE && state != ISSUE) sum_out <= acc_nxt;
  end

endmodule

// File: tb/tb_sumsq_accum.sv
// Directed bench for sumsq_accum; works for both the combinational and the SUMSQ_PIPE_EN build.
module tb_sumsq_accum;

  localparam int DATA_W = 8;
  localparam int N_ELEM = 4;
  localparam int ACC_W  = 18;
`ifdef SUMSQ_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              clr_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              sqrt_done = 1'b0;
  logic              go;
  logic [ACC_W-1:0]  sum_out;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int go_cnt = 0;

  sumsq_accum #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .ACC_W(ACC_W)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .sqrt_done(sqrt_done),
    .go(go), .sum_out(sum_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (go === 1'b1) go_cnt++;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int d);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the last accept edge.
  task automatic wait_go(input string tag, input longint exp_sum);
    int k = 0;
    int g0;
    while (go !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, k, LAT - 1);
    chk({tag, "_go"}, go, 1);
    chk({tag, "_sum"}, sum_out, exp_sum);
    g0 = go_cnt;
    tick();
    chk({tag, "_go_pulse"}, go, 0);
    chk({tag, "_hold"}, sum_out, exp_sum);
    chk({tag, "_busy_wait"}, busy, 1);
    chk({tag, "_one_go"}, go_cnt - g0, 1);
  endtask

  task automatic finish_wait();
    sqrt_done = 1'b1;
    tick();
    sqrt_done = 1'b0;
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int g0;
    #2;
    chk("rst_go", go, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum_out, 0);
    tick();
    clr_n = 1'b1;
    tick();

    // 3,4,0,0 back-to-back
    do_start();
    chk("v1_busy", busy, 1);
    chk("v1_ready", in_ready, 1);
    feed(3); feed(4); feed(0); feed(0);
    chk("v1_ready_off", in_ready, 0);
    wait_go("v1", 25);
    finish_wait();

    // extreme negative: 4 * 16384
    do_start();
    feed(-128); feed(-128); feed(-128); feed(-128);
    wait_go("neg", 65536);
    finish_wait();

    do_start();
    feed(127); feed(127); feed(127); feed(127);
    wait_go("pos", 64516);
    finish_wait();

    // valid gaps 1,0,0,1,1,0,1 with junk data on idle cycles; start pulse mid-ACC
    do_start();
    chk("nostart_clear", sum_out, 64516);
    feed(1);
    in_data = 8'd9; tick();
    start = 1'b1; in_data = 8'd9; tick(); start = 1'b0;
    chk("acc_start_ign", busy, 1);
    feed(2); feed(3);
    in_data = 8'd9; tick();
    feed(4);
    g0 = go_cnt;
    wait_go("gap", 30);
    start = 1'b1; tick(); start = 1'b0;
    chk("wait_start_ign_busy", busy, 1);
    chk("wait_start_ign_sum", sum_out, 30);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wait_go_low", go, 0);
      chk("wait_sum_stable", sum_out, 30);
    end
    chk("gap_go_total", go_cnt - g0, 1);
    finish_wait();
    chk("idle_ready", in_ready, 0);

    // reset mid-vector after two accepts
    do_start();
    feed(5); feed(6);
    g0 = go_cnt;
    clr_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_go", go, 0);
    chk("mid_rst_sum", sum_out, 0);
    #2 clr_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_no_go", go_cnt - g0, 0);
    chk("mid_rst_idle", busy, 0);
    do_start();
    feed(1); feed(1); feed(1); feed(1);
    wait_go("after_rst", 4);
    finish_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
